comp_seq: RTL
=============

Name: comp_seq

Overview:
- Parametrised, multi-cycle, cascadable magnitude comparator. It is the successor of the team's 4-bit combinational cascade comparator.
- Latches two WIDTH-bit operands plus upper-order cascade inputs on a start pulse.
- Compares SLICE bits per cycle, most-significant slice first, and stops early at the first unequal slice.
- Sits in the datapath wherever wide operands must be ordered without a long combinational chain. Optional two's-complement mode.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of SLICE (elaboration error otherwise).
- SLICE, 4, bits compared per cycle; NSLICE = WIDTH/SLICE.
- SIGNED, 0, 1 = operands are two's complement (sign applied to the MSB slice only); 0 = unsigned.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when busy=0
- A  input  WIDTH  operand A, sampled on the accepting edge
- B  input  WIDTH  operand B, sampled on the accepting edge
- in_A_G_B  input  1  cascade: upper-order stage says A>B
- in_A_E_B  input  1  cascade: upper-order stage says A==B
- in_A_L_B  input  1  cascade: upper-order stage says A<B
- busy  output  1  high while slices are being compared
- done  output  1  one-cycle pulse when a new result is valid
- out_A_G_B  output  1  result A>B, held until next result
- out_A_E_B  output  1  result A==B, held until next result
- out_A_L_B  output  1  result A<B, held until next result

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, out_A_G_B=0, out_A_E_B=0, out_A_L_B=0, slice pointer=0. Reset mid-comparison abandons the operation; no done is issued.
- States: IDLE, CMP. The done pulse is registered; it is not a separate state.
- IDLE + start=1, cascade 100: result GT written, done=1 on that same edge, stays in IDLE, busy never rises.
- IDLE + start=1, cascade 010: latch A and B, ptr=NSLICE-1, go to CMP, busy=1.
- IDLE + start=1, any other cascade pattern (001, 000, 011, 111, ...): result LT written, done=1 on the same edge, stays in IDLE. Invalid patterns resolve to LT.
- CMP, each cycle: combinationally compare slice ptr of the latched operands. On the next edge:
  - if the slices are unequal, write GT or LT;
  - else if ptr==0, write EQ;
  - else ptr decrements and the state stays CMP.
  - On writing a result: done=1, busy=0, state returns to IDLE.
- Latency in edges after the accepting edge:
  - cascade-decided: 0;
  - otherwise j, where j is the 1-based position of the first unequal slice counted from the MSB;
  - all slices equal: NSLICE.
- Exactly one of the three result outputs is 1 after the first result; all are 0 only after reset.
- Result outputs change only on an edge that raises done.
- done is high for exactly one cycle unless a back-to-back cascade-decided start re-raises it.
- start while busy=1 is ignored, not queued. A and B changes during CMP have no effect.
- start in the cycle where done=1 (busy=0) is accepted normally.
- SIGNED=1: the MSB slice is compared as a signed SLICE-bit value; lower slices are compared unsigned. SIGNED=0: all slices are compared unsigned.

Decomposition:
- Shared package comp_pkg holds:
  - state typedef (IDLE, CMP);
  - cascade encoding constants CASC_GT=3'b100, CASC_EQ=3'b010, CASC_LT=3'b001.
- One sub-module, comp_slice: a combinational SLICE-bit comparator.
  - Parameter: SLICE.
  - Inputs: a, b, is_signed.
  - Outputs: gt, eq, lt.
  - Instantiated once and fed the slice selected by ptr.

Test Plan (WIDTH=16, SLICE=4):
1. Cascade 100, A=0x0000, B=0xFFFF, start -> done on the accepting edge, out=GT, busy stays 0.
2. Cascade 010, A=B=0x1234 -> busy for 4 cycles, done 4 edges after accept, out=EQ.
3. Cascade 010, A=0x1234, B=0x1334 -> done at edge 2, out=LT. Assert start again while busy with A=0xFFFF, B=0 -> ignored, result still LT.
4. SIGNED=1, A=0x8000, B=0x0001 -> done at edge 1, LT. Same stimulus with SIGNED=0 -> GT.
5. Cascade 111, then cascade 000, any operands -> each gives done at the accepting edge, out=LT.
6. Cascade 010, A=0xABCD, B=0xABCC; pull rst_n low after edge 2 -> outputs 000, busy=0, no done. After release, a new start with cascade 010, A=0xABCD, B=0xABCC -> done at edge 4, out=GT.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared types and constants for the multi-cycle cascadable comparator.
package comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  // Cascade / result encoding, ordered {A>B, A==B, A<B}.
  localparam logic [2:0] CASC_GT = 3'b100;
  localparam logic [2:0] CASC_EQ = 3'b010;
  localparam logic [2:0] CASC_LT = 3'b001;

endpackage

// File: rtl/comp_slice.sv
// Combinational SLICE-bit magnitude comparator with optional signed interpretation.
module comp_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             is_signed,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  always_comb begin
    eq = (a == b);
    if (is_signed) begin
      gt = ($signed(a) > $signed(b));
      lt = ($signed(a) < $signed(b));
    end else begin
      gt = (a > b);
      lt = (a < b);
    end
  end

endmodule

// File: rtl/comp_seq.sv
// Multi-cycle cascadable magnitude comparator: one SLICE per cycle, MSB slice first,
// early exit on the first unequal slice.
module comp_seq
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SLICE  = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_A_G_B,
  input  logic             in_A_E_B,
  input  logic             in_A_L_B,
  output logic             busy,
  output logic             done,
  output logic             out_A_G_B,
  output logic             out_A_E_B,
  output logic             out_A_L_B
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned PTR_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((SLICE == 0) || ((WIDTH % SLICE) != 0)) begin : g_width_check
    $error("comp_seq: WIDTH must be a non-zero multiple of SLICE");
  end

  state_t                       state, state_nxt;
  logic [PTR_W-1:0]             ptr, ptr_nxt;
  logic [NSLICE-1:0][SLICE-1:0] a_q, a_nxt;
  logic [NSLICE-1:0][SLICE-1:0] b_q, b_nxt;
  logic                         busy_nxt, done_nxt;
  logic [2:0]                   res_q, res_nxt;

  logic [2:0] casc;
  logic       s_gt, s_eq, s_lt;
  logic       msb_signed;

  assign casc       = {in_A_G_B, in_A_E_B, in_A_L_B};
  // Sign only matters for the most significant slice.
  assign msb_signed = (SIGNED != 0) && (ptr == PTR_W'(NSLICE - 1));

  comp_slice #(.SLICE(SLICE)) u_slice (
    .a         (a_q[ptr]),
    .b         (b_q[ptr]),
    .is_signed (msb_signed),
    .gt        (s_gt),
    .eq        (s_eq),
    .lt        (s_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res_q <= 3'b000;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      res_q <= res_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    a_nxt     = a_q;
    b_nxt     = b_q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    res_nxt   = res_q;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (casc == CASC_GT) begin
            res_nxt  = CASC_GT;
            done_nxt = 1'b1;
          end else if (casc == CASC_EQ) begin
            a_nxt     = A;
            b_nxt     = B;
            ptr_nxt   = PTR_W'(NSLICE - 1);
            busy_nxt  = 1'b1;
            state_nxt = CMP;
          end else begin
            // Every non-one-hot or LT pattern resolves to LT.
            res_nxt  = CASC_LT;
            done_nxt = 1'b1;
          end
        end
      end
      CMP: begin
        if (!s_eq) begin
          res_nxt   = {s_gt, 1'b0, s_lt};
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (ptr == '0) begin
          res_nxt   = CASC_EQ;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          ptr_nxt = ptr - PTR_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_A_G_B = res_q[2];
  assign out_A_E_B = res_q[1];
  assign out_A_L_B = res_q[0];

endmodule
